ldl_p1ram_arb: RTL and testbench

- Front-end controller for the team's single-port synchronous RAM (one registered read port, one write port, shared address, read data one cycle after a read enable).
- Accepts independent write and read request streams with valid/ready handshakes and arbitrates them onto the single port, at most one access per cycle.
- Returns read data on a valid/ready response stream with a small credit-managed buffer, so response backpressure never loses RAM data.
- Sits directly upstream of the RAM and drives all of its control, address and write-data inputs.

---
 rtl/ldl_p1ram_arb.sv | 166 ++++++++++++++++
 tb/tb_ldl_p1ram_arb.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldl_p1ram_arb.sv
`default_nettype none
// ============================================================================
// Module   : ldl_p1ram_arb
// Purpose  : Front-end controller for a single-port synchronous RAM. It
//            arbitrates independent write and read request streams onto the
//            single RAM port (at most one access per cycle) and returns read
//            data through a small credit-managed response FIFO, so response
//            backpressure never loses RAM data.
// Ports    : clk, rst                      clock, synchronous active-high reset
//            i_wr_valid/o_wr_ready         write request handshake
//            i_wr_addr, i_wr_data          write address / data
//            i_rd_valid/o_rd_ready         read request handshake
//            i_rd_addr                     read address
//            o_rsp_valid/i_rsp_ready       read response handshake
//            o_rsp_data, o_rsp_err         response data / out-of-range marker
//            o_oor_err                     sticky out-of-range access flag
//            o_ram_re, o_ram_we            RAM read / write enables
//            o_ram_addr, o_ram_din         RAM address / write data
//            i_ram_dout                    RAM read data (cycle after o_ram_re)
// Revision : 1.0 - initial release
// ============================================================================
module ldl_p1ram_arb #(
    parameter int DWIDTH = 8,
    parameter int DEEPTH = 10,
    parameter int AWIDTH = $clog2(DEEPTH),
    parameter int RDEPTH = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [AWIDTH-1:0] i_wr_addr,
    input  logic [DWIDTH-1:0] i_wr_data,
    input  logic              i_rd_valid,
    output logic              o_rd_ready,
    input  logic [AWIDTH-1:0] i_rd_addr,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DWIDTH-1:0] o_rsp_data,
    output logic              o_rsp_err,
    output logic              o_oor_err,
    output logic              o_ram_re,
    output logic              o_ram_we,
    output logic [AWIDTH-1:0] o_ram_addr,
    output logic [DWIDTH-1:0] o_ram_din,
    input  logic [DWIDTH-1:0] i_ram_dout
);

    // Occupancy counter must hold 0..RDEPTH; pointers index 0..RDEPTH-1.
    localparam int c_OW = $clog2(RDEPTH + 1);
    localparam int c_PW = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;

    localparam logic [AWIDTH:0] c_DEPTH_EXT = (AWIDTH + 1)'(DEEPTH);
    localparam logic [c_OW:0]   c_RD_LIMIT  = (c_OW + 1)'(RDEPTH);
    localparam logic [c_PW-1:0] c_PLAST     = c_PW'(RDEPTH - 1);

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [DWIDTH:0]   r_buf [RDEPTH];   // {err, data} per entry
    logic [c_PW-1:0]   r_wptr;
    logic [c_PW-1:0]   r_rptr;
    logic [c_OW-1:0]   r_occ;
    logic              r_inflight;       // a read was accepted last cycle
    logic              r_infl_err;       // ...and it was out of range
    logic              r_last_wr;        // last grant went to the write side
    logic              r_oor_err;

    // ------------------------------------------------------------------------
    // Combinational arbitration
    // ------------------------------------------------------------------------
    logic [c_OW:0]     w_used;
    logic              w_rd_elig;
    logic              w_rd_req;
    logic              w_wr_gnt;
    logic              w_rd_gnt;
    logic              w_wr_oor;
    logic              w_rd_oor;
    logic              w_push;
    logic              w_pop;
    logic [DWIDTH:0]   w_push_word;

    always_comb begin
        // Credit is taken from registered state only, so rd_ready never
        // depends combinationally on rsp_ready.
        w_used    = {1'b0, r_occ} + (c_OW + 1)'(r_inflight);
        w_rd_elig = (w_used < c_RD_LIMIT);
        w_rd_req  = i_rd_valid && w_rd_elig;

        // Round-robin on a tie: the side not granted last time wins.
        w_wr_gnt  = i_wr_valid && (!w_rd_req || !r_last_wr);
        w_rd_gnt  = w_rd_req && (!i_wr_valid || r_last_wr);

        w_wr_oor  = ({1'b0, i_wr_addr} >= c_DEPTH_EXT);
        w_rd_oor  = ({1'b0, i_rd_addr} >= c_DEPTH_EXT);

        w_push    = r_inflight;
        w_pop     = o_rsp_valid && i_rsp_ready;

        // An out-of-range read never touched the RAM, so its data is forced
        // to zero instead of taking whatever ram_dout happens to hold.
        w_push_word = {r_infl_err, (r_infl_err ? {DWIDTH{1'b0}} : i_ram_dout)};
    end

    always_comb begin
        o_wr_ready = w_wr_gnt;
        o_rd_ready = w_rd_gnt;
        o_ram_we   = w_wr_gnt && !w_wr_oor;
        o_ram_re   = w_rd_gnt && !w_rd_oor;
        o_ram_addr = '0;
        o_ram_din  = '0;
        if (o_ram_we) begin
            o_ram_addr = i_wr_addr;
            o_ram_din  = i_wr_data;
        end else if (o_ram_re) begin
            o_ram_addr = i_rd_addr;
        end
    end

    assign o_rsp_valid = (r_occ != '0);
    assign o_rsp_data  = r_buf[r_rptr][DWIDTH-1:0];
    assign o_rsp_err   = r_buf[r_rptr][DWIDTH];
    assign o_oor_err   = r_oor_err;

    // ------------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RDEPTH; i++) begin
                r_buf[i] <= '0;
            end
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_occ      <= '0;
            r_inflight <= 1'b0;
            r_infl_err <= 1'b0;
            r_last_wr  <= 1'b0;
            r_oor_err  <= 1'b0;
        end else begin
            r_inflight <= w_rd_gnt;
            r_infl_err <= w_rd_gnt && w_rd_oor;

            if (w_wr_gnt) begin
                r_last_wr <= 1'b1;
            end else if (w_rd_gnt) begin
                r_last_wr <= 1'b0;
            end

            if ((w_wr_gnt && w_wr_oor) || (w_rd_gnt && w_rd_oor)) begin
                r_oor_err <= 1'b1;
            end

            if (w_push) begin
                r_buf[r_wptr] <= w_push_word;
                r_wptr        <= (r_wptr == c_PLAST) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_PLAST) ? '0 : r_rptr + 1'b1;
            end
            r_occ <= r_occ + c_OW'(w_push) - c_OW'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ldl_p1ram_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_ldl_p1ram_arb
// Purpose  : Self-checking bench for ldl_p1ram_arb with a behavioural RAM,
//            directed scenarios, randomized traffic and a scoreboard monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ldl_p1ram_arb;

    localparam int DW = 8;
    localparam int DEEPTH = 10;
    localparam int AW = 4;
    localparam int RDEPTH = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid = 1'b0;
    logic          rd_ready;
    logic [AW-1:0] rd_addr = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          oor_err;
    logic          ram_re;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout = '0;

    always #5 clk = ~clk;

    ldl_p1ram_arb #(.DWIDTH(DW), .DEEPTH(DEEPTH), .AWIDTH(AW), .RDEPTH(RDEPTH)) dut (
        .clk(clk), .rst(rst),
        .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
        .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_rd_valid(rd_valid), .o_rd_ready(rd_ready), .i_rd_addr(rd_addr),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_data(rsp_data), .o_rsp_err(rsp_err), .o_oor_err(oor_err),
        .o_ram_re(ram_re), .o_ram_we(ram_we),
        .o_ram_addr(ram_addr), .o_ram_din(ram_din), .i_ram_dout(ram_dout)
    );

    // Behavioural single-port RAM with registered read.
    logic [DW-1:0] ram [16];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_din;
        if (ram_re) ram_dout <= ram[ram_addr];
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model + scoreboard monitor.
    // Outstanding responses (accepted, not yet consumed) are the queue; read
    // credit is simply "fewer than RDEPTH outstanding". A response becomes
    // visible two cycles after the cycle its read was accepted.
    // ------------------------------------------------------------------------
    typedef struct {
        int d;
        int e;
        int c;
    } rsp_t;

    rsp_t    sb[$];
    logic [DW-1:0] shadow [16];
    int      cyc = 0;
    bit      last_wr = 0;
    bit      exp_oor = 0;
    int      n_we = 0, n_pop = 0, n_push = 0, n_disc = 0;

    always @(negedge clk) begin
        bit elig, ewg, erg, ev, wio, rio;
        int ea, ed;
        cyc++;
        if (rst) begin
            n_disc += sb.size();
            sb.delete();
            last_wr = 0;
            exp_oor = 0;
        end else begin
            elig = (sb.size() < RDEPTH);
            ewg  = wr_valid && (!(rd_valid && elig) || !last_wr);
            erg  = rd_valid && elig && (!wr_valid || last_wr);
            wio  = (int'(wr_addr) < DEEPTH);
            rio  = (int'(rd_addr) < DEEPTH);
            chk("wr_ready", int'(wr_ready), int'(ewg));
            chk("rd_ready", int'(rd_ready), int'(erg));
            chk("ram_we", int'(ram_we), int'(ewg && wio));
            chk("ram_re", int'(ram_re), int'(erg && rio));
            chk("re_we_excl", int'(ram_re && ram_we), 0);
            ea = (ewg && wio) ? int'(wr_addr) : ((erg && rio) ? int'(rd_addr) : 0);
            ed = (ewg && wio) ? int'(wr_data) : 0;
            chk("ram_addr", int'(ram_addr), ea);
            chk("ram_din", int'(ram_din), ed);
            chk("oor_err", int'(oor_err), int'(exp_oor));
            if (ram_we) n_we++;
            if (rsp_valid && rsp_ready) n_pop++;
            ev = (sb.size() > 0) && ((cyc - sb[0].c) >= 2);
            chk("rsp_valid", int'(rsp_valid), int'(ev));
            if (ev) begin
                chk("rsp_data", int'(rsp_data), sb[0].d);
                chk("rsp_err", int'(rsp_err), sb[0].e);
                if (rsp_ready) void'(sb.pop_front());
            end
            if (ewg) begin
                last_wr = 1;
                if (wio) shadow[wr_addr] = wr_data;
                else exp_oor = 1;
            end
            if (erg) begin
                last_wr = 0;
                if (rio) sb.push_back('{int'(shadow[rd_addr]), 0, cyc});
                else begin
                    sb.push_back('{0, 1, cyc});
                    exp_oor = 1;
                end
                n_push++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t required < 500000", $time);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int a, input int d);
        bit ok = 0;
        wr_valid = 1'b1;
        wr_addr  = AW'(a);
        wr_data  = DW'(d);
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = wr_ready;
            step();
        end
        wr_valid = 1'b0;
        chk("wr_accept_timeout", int'(ok), 1);
    endtask

    task automatic do_read(input int a);
        bit ok = 0;
        rd_valid = 1'b1;
        rd_addr  = AW'(a);
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = rd_ready;
            step();
        end
        rd_valid = 1'b0;
        chk("rd_accept_timeout", int'(ok), 1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int n0, acc;
        repeat (3) step();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_data", int'(rsp_data), 0);
        chk("rst_rsp_err", int'(rsp_err), 0);
        chk("rst_oor_err", int'(oor_err), 0);
        step();

        // Write then read back, with latency check
        n0 = n_we;
        do_write(3, 8'hA5);
        chk("we_pulses", n_we - n0, 1);
        rsp_ready = 1'b1;
        do_read(3);
        @(negedge clk);
        chk("lat_cycle1", int'(rsp_valid), 0);
        @(negedge clk);
        chk("lat_cycle2", int'(rsp_valid), 1);
        chk("lat_data", int'(rsp_data), 8'hA5);
        chk("lat_err", int'(rsp_err), 0);
        step();

        // Preload 0x10+addr
        for (int a = 0; a < DEEPTH; a++) do_write(a, 8'h10 + a);
        repeat (3) step();

        // Tie alternation after reset: W,R,W,R,W,R
        pulse_reset();
        wr_valid = 1'b1; wr_addr = 4'd5; wr_data = 8'h15;
        rd_valid = 1'b1; rd_addr = 4'd7;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("alternate", int'({wr_ready, rd_ready}), (i % 2 == 0) ? 2 : 1);
            step();
        end
        wr_valid = 1'b0; rd_valid = 1'b0;
        repeat (4) step();

        // Back-to-back reads at full throughput
        rd_valid = 1'b1;
        for (int i = 0; i < DEEPTH; i++) begin
            rd_addr = AW'(i);
            @(negedge clk);
            chk("throughput_rd_ready", int'(rd_ready), 1);
            step();
        end
        rd_valid = 1'b0;
        repeat (4) step();

        // Backpressure: credit limit then drain
        rsp_ready = 1'b0;
        rd_valid  = 1'b1;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rd_ready) acc++;
            step();
            rd_addr = AW'(acc);
        end
        chk("stall_accepts", acc, RDEPTH);
        @(negedge clk);
        chk("stall_rd_ready", int'(rd_ready), 0);
        step();
        rd_valid = 1'b0;
        n0 = n_pop;
        rsp_ready = 1'b1;
        repeat (6) step();
        chk("stall_drained", n_pop - n0, RDEPTH);

        // Out-of-range accesses
        do_write(12, 8'h77);
        do_read(15);
        repeat (3) step();
        @(negedge clk);
        chk("oor_sticky", int'(oor_err), 1);
        step();
        repeat (5) step();
        @(negedge clk);
        chk("oor_sticky_later", int'(oor_err), 1);
        step();

        // Reset with 2 buffered responses and 1 read in flight
        rsp_ready = 1'b0;
        rd_valid  = 1'b1;
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            rd_addr = AW'(i + 1);
            @(negedge clk);
            if (rd_ready) acc++;
            step();
        end
        chk("pre_reset_accepts", acc, 3);
        rd_valid = 1'b0;
        pulse_reset();
        @(negedge clk);
        chk("post_rst_data", int'(rsp_data), 0);
        chk("post_rst_oor", int'(oor_err), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", int'(rsp_valid), 0);
            step();
        end
        rsp_ready = 1'b1;
        for (int a = 1; a <= 3; a++) do_read(a);
        repeat (4) step();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            wr_valid  = ($urandom_range(0, 99) < 45);
            rd_valid  = ($urandom_range(0, 99) < 60);
            wr_addr   = AW'($urandom_range(0, 15));
            wr_data   = DW'($urandom);
            rd_addr   = AW'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 99) < 70);
            step();
        end
        wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
        repeat (10) step();
        chk("all_responses_returned", n_pop, n_push - n_disc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
